list_stream_harness: RTL and testbench

//  Parametrised on-chip driver/capture harness for a generated list-producing dataflow block (req/ack/eol/value protocol).
//  - Launches the DUT, issues element requests with programmable pacing and stores returned elements in a RAM.
//  - Detects end-of-list, overflow and stall timeout.
//  - Sits between board top level (start pulse, LED/status) and the DUT. Replaces the free-running timer-toggle bench.

---
 rtl/list_harness_pkg.sv | 27 ++
 rtl/list_capture_ram.sv | 32 +++
 rtl/list_stream_harness.sv | 153 +++++++++++++++
 tb/tb_list_stream_harness.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_harness_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : list_harness_pkg
//  Description : Shared types and helpers for the list stream harness:
//                FSM state encoding and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package list_harness_pkg;

    // Harness run states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ABORT  = 3'd5
    } state_t;

    // Bits needed to hold 0..max_value; never less than one bit so that a
    // zero-valued parameter still yields a legal vector.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage : list_harness_pkg
`default_nettype wire

// File: rtl/list_capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : list_capture_ram
//  Description : Simple dual-port RAM, WIDTH x DEPTH, synchronous write and
//                registered read. Read-during-write to the same address
//                returns the previous contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module list_capture_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port and registered read port; no reset so the array maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule : list_capture_ram
`default_nettype wire

// File: rtl/list_stream_harness.sv
`default_nettype none
// ============================================================================
//  Module      : list_stream_harness
//  Description : Driver/capture harness for a list-producing dataflow block.
//                Launches the block, paces element requests, captures the
//                returned elements into RAM and reports end-of-list,
//                overflow and ack-stall timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module list_stream_harness
    import list_harness_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int GAP     = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     start,
    output logic                     dut_ready,
    input  logic                     dut_done,
    output logic                     req,
    input  logic                     ack,
    input  logic                     eol,
    input  logic [WIDTH-1:0]         value,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     finished,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_CNT_W   = c_ADDR_W + 1;
    localparam int c_GAP_W   = cnt_width(GAP);
    localparam int c_STALL_W = cnt_width(TIMEOUT);

    // count value at which the RAM is full
    localparam logic [c_CNT_W-1:0]   c_FULL       = c_CNT_W'(DEPTH);
    // Last gap-counter value before req reasserts; GAP=0 still idles one cycle
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'((GAP == 0) ? 0 : GAP - 1);
    // Last stall-counter value tolerated before the run is aborted
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT - 1);

    state_t                 r_state;
    logic [c_GAP_W-1:0]     r_gap_cnt;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic                   w_wr_en;

    // Capture an element only on a real handshake with room left in the RAM
    assign w_wr_en = (r_state == ST_REQ) && ack && !eol && (count != c_FULL);

    // Run-control FSM with registered outputs, gap/stall counters and flags
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_stall_cnt <= '0;
            dut_ready   <= 1'b0;
            req         <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ABORT: begin
                    if (start) begin
                        r_state   <= ST_LAUNCH;
                        dut_ready <= 1'b1;
                        busy      <= 1'b1;
                        count     <= '0;
                        finished  <= 1'b0;
                        overflow  <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end

                ST_LAUNCH: begin
                    if (dut_done) begin
                        r_state     <= ST_REQ;
                        req         <= 1'b1;
                        r_stall_cnt <= '0;
                    end
                end

                ST_REQ: begin
                    if (ack) begin
                        req <= 1'b0;
                        if (eol) begin
                            r_state   <= ST_DONE;
                            finished  <= 1'b1;
                            dut_ready <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            // Past capacity the list is still drained to eol
                            if (count != c_FULL) begin
                                count <= count + c_CNT_W'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                        end
                    end else if (r_stall_cnt == c_STALL_LAST) begin
                        r_state   <= ST_ABORT;
                        req       <= 1'b0;
                        dut_ready <= 1'b0;
                        busy      <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state     <= ST_REQ;
                        req         <= 1'b1;
                        r_stall_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    req       <= 1'b0;
                    dut_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    list_capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLOCK_50),
        .wr_en   (w_wr_en),
        .wr_addr (count[c_ADDR_W-1:0]),
        .wr_data (value),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule : list_stream_harness
`default_nettype wire

// File: tb/tb_list_stream_harness.sv
`default_nettype none
// ============================================================================
//  Module      : tb_list_stream_harness
//  Description : Self-checking bench for list_stream_harness. Instance A uses
//                GAP=5/TIMEOUT=20 with a reactive list model; instance B uses
//                GAP=0 with ack held high. RAM read-backs go through an
//                expectation queue checked by a separate monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_list_stream_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A signals
    logic       start_a, dut_ready_a, dut_done_a, req_a, ack_a, eol_a;
    logic [7:0] value_a, rd_data_a;
    logic [3:0] rd_addr_a;
    logic [4:0] count_a;
    logic       busy_a, finished_a, overflow_a, timeout_a;

    // Instance B signals
    logic       start_b, dut_ready_b, dut_done_b, req_b, ack_b, eol_b;
    logic [7:0] value_b, rd_data_b;
    logic [3:0] rd_addr_b;
    logic [4:0] count_b;
    logic       busy_b, finished_b, overflow_b, timeout_b;

    list_stream_harness #(.WIDTH(8), .DEPTH(16), .GAP(5), .TIMEOUT(20)) dut_a (
        .CLOCK_50 (clk),        .reset    (reset),      .start    (start_a),
        .dut_ready(dut_ready_a),.dut_done (dut_done_a), .req      (req_a),
        .ack      (ack_a),      .eol      (eol_a),      .value    (value_a),
        .rd_addr  (rd_addr_a),  .rd_data  (rd_data_a),  .count    (count_a),
        .busy     (busy_a),     .finished (finished_a), .overflow (overflow_a),
        .timeout  (timeout_a)
    );

    list_stream_harness #(.WIDTH(8), .DEPTH(16), .GAP(0), .TIMEOUT(20)) dut_b (
        .CLOCK_50 (clk),        .reset    (reset),      .start    (start_b),
        .dut_ready(dut_ready_b),.dut_done (dut_done_b), .req      (req_b),
        .ack      (ack_b),      .eol      (eol_b),      .value    (value_b),
        .rd_addr  (rd_addr_b),  .rd_data  (rd_data_b),  .count    (count_b),
        .busy     (busy_b),     .finished (finished_b), .overflow (overflow_b),
        .timeout  (timeout_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- RAM read scoreboard ----------------
    typedef struct {
        bit         inst;
        int         addr;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    bit      rd_en   = 1'b0;
    bit      rd_inst = 1'b0;

    task automatic read_ram(input bit inst, input int addr, input logic [7:0] exp);
        rd_exp_t e;
        @(posedge clk); #1;
        rd_en   = 1'b1;
        rd_inst = inst;
        if (inst) rd_addr_b = 4'(addr);
        else      rd_addr_a = 4'(addr);
        e.inst = inst; e.addr = addr; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic read_end();
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : rd_monitor
        bit      v;
        bit      which;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            v     = rd_en;
            which = rd_inst;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("ram_%s[%0d]", e.inst ? "b" : "a", e.addr),
                          int'(e.inst ? rd_data_b : rd_data_a), int'(e.exp));
                    if (e.inst != which) check("rd_inst_order", 1, 0);
                end
            end
        end
    end

    // ---------------- Instance A list model ----------------
    logic [7:0] model_list[$];
    bit         model_never = 1'b0;

    initial begin : model_a
        int rc;
        rc = 0;
        ack_a = 1'b0; eol_a = 1'b0; value_a = 8'h00; dut_done_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            dut_done_a = dut_ready_a;
            ack_a = 1'b0;
            eol_a = 1'b0;
            if (req_a) begin
                rc++;
                if (rc == 3 && !model_never) begin
                    ack_a = 1'b1;
                    rc    = 0;
                    if (model_list.size() > 0) begin
                        value_a = model_list.pop_front();
                    end else begin
                        eol_a   = 1'b1;
                        value_a = 8'h55;
                    end
                end
            end else begin
                rc = 0;
            end
        end
    end

    // Instance A req monitor: counts req pulses and measures low gaps in a run
    int rises_a    = 0;
    int rise_cyc_a = 0;
    bit ra_prev    = 1'b0;
    bit ra_track   = 1'b0;
    int ra_len     = 0;

    initial begin : mon_req_a
        forever begin
            @(posedge clk); #1;
            if (req_a && !ra_prev) begin
                rises_a++;
                rise_cyc_a = cyc;
                if (ra_track) check("gap_len_a", ra_len, 5);
                ra_track = 1'b0;
            end else if (!req_a && ra_prev && busy_a) begin
                ra_track = 1'b1;
                ra_len   = 1;
            end else if (!req_a && ra_track) begin
                if (busy_a) ra_len++;
                else        ra_track = 1'b0;
            end
            ra_prev = req_a;
        end
    end

    // ---------------- Instance B value model ----------------
    bit rb_last = 1'b0;

    initial begin : model_b
        forever begin
            @(posedge clk); #1;
            if (rb_last && ack_b) value_b = value_b + 8'd1;
            rb_last = req_b;
        end
    end

    task automatic pulse_start_a();
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (busy_a && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, int'(busy_a), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed test sequence ----------------
    initial begin : stim
        logic [7:0] e1 [3];
        int n;
        e1[0] = 8'hFE; e1[1] = 8'h04; e1[2] = 8'h07;

        reset = 1'b1;
        start_a = 1'b0; rd_addr_a = 4'd0;
        start_b = 1'b0; rd_addr_b = 4'd0;
        ack_b = 1'b0; eol_b = 1'b0; value_b = 8'h00; dut_done_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",       int'(req_a),       0);
        check("rst_dut_ready", int'(dut_ready_a), 0);
        check("rst_count",     int'(count_a),     0);
        check("rst_busy",      int'(busy_a),      0);
        check("rst_finished",  int'(finished_a),  0);
        check("rst_overflow",  int'(overflow_a),  0);
        check("rst_timeout",   int'(timeout_a),   0);
        check("rst_busy_b",    int'(busy_b),      0);
        reset = 1'b0;

        // Test 1: three elements then eol
        model_list = '{8'hFE, 8'h04, 8'h07};
        pulse_start_a();
        check("t1_busy", int'(busy_a), 1);
        wait_idle_a("t1_end");
        check("t1_count",    int'(count_a),    3);
        check("t1_finished", int'(finished_a), 1);
        check("t1_overflow", int'(overflow_a), 0);
        check("t1_timeout",  int'(timeout_a),  0);
        for (int i = 0; i < 3; i++) read_ram(1'b0, i, e1[i]);
        read_end();

        // Test 2: empty list
        model_list.delete();
        rises_a = 0;
        pulse_start_a();
        wait_idle_a("t2_end");
        check("t2_count",     int'(count_a),    0);
        check("t2_finished",  int'(finished_a), 1);
        check("t2_req_pulse", rises_a,          1);

        // Test 3: DEPTH+2 elements
        model_list.delete();
        for (int k = 0; k < 18; k++) model_list.push_back(8'(k * 7 + 3));
        pulse_start_a();
        wait_idle_a("t3_end");
        check("t3_overflow", int'(overflow_a), 1);
        check("t3_count",    int'(count_a),    16);
        check("t3_finished", int'(finished_a), 1);
        for (int k = 0; k < 16; k++) read_ram(1'b0, k, 8'(k * 7 + 3));
        read_end();

        // Test 4: no ack ever -> timeout 20 cycles after req rise
        model_never = 1'b1;
        pulse_start_a();
        n = 0;
        while (!timeout_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_timeout",   int'(timeout_a),   1);
        check("t4_latency",   cyc - rise_cyc_a,  20);
        check("t4_req",       int'(req_a),       0);
        check("t4_dut_ready", int'(dut_ready_a), 0);
        check("t4_busy",      int'(busy_a),      0);
        check("t4_finished",  int'(finished_a),  0);
        model_never = 1'b0;

        // Test 5: reset in the middle of a run, then a clean run
        model_list = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pulse_start_a();
        n = 0;
        while (!(count_a == 5'd2 && req_a) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached", int'(count_a == 5'd2 && req_a), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_req",       int'(req_a),       0);
        check("t5_dut_ready", int'(dut_ready_a), 0);
        check("t5_count",     int'(count_a),     0);
        check("t5_busy",      int'(busy_a),      0);
        check("t5_finished",  int'(finished_a),  0);
        check("t5_overflow",  int'(overflow_a),  0);
        check("t5_timeout",   int'(timeout_a),   0);
        reset = 1'b0;
        model_list = '{8'h11, 8'h22};
        pulse_start_a();
        wait_idle_a("t5_end");
        check("t5_count2",    int'(count_a),    2);
        check("t5_finished2", int'(finished_a), 1);
        read_ram(1'b0, 0, 8'h11);
        read_ram(1'b0, 1, 8'h22);
        read_end();

        // Test 6: GAP=0, ack held high, start ignored while busy
        ack_b = 1'b1; eol_b = 1'b0; value_b = 8'h40;
        @(posedge clk); #1; start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        n = 0;
        while (!req_b && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_first_req", int'(req_b),   1);
        check("t6_count0",    int'(count_b), 0);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 4) start_b = 1'b1;
            if (i == 5) start_b = 1'b0;
            check($sformatf("t6_req_%0d", i), int'(req_b), (i % 2 == 0) ? 1 : 0);
        end
        check("t6_count5", int'(count_b), 5);
        eol_b = 1'b1;
        @(posedge clk); #1;
        check("t6_finished", int'(finished_b), 1);
        check("t6_busy",     int'(busy_b),     0);
        check("t6_count",    int'(count_b),    5);
        check("t6_overflow", int'(overflow_b), 0);
        ack_b = 1'b0; eol_b = 1'b0;
        for (int i = 0; i < 5; i++) read_ram(1'b1, i, 8'(8'h40 + i));
        read_end();

        check("rd_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_list_stream_harness
`default_nettype wire
